// File: rtl/fifo_rd_checker.sv
// rtl/fifo_rd_checker.sv - FIFO read-side pattern checker (incrementing or LFSR expected stream)
module fifo_rd_checker #(
  parameter int unsigned DWIDTH  = 8,
  parameter int unsigned CWIDTH  = 16,
  parameter logic [31:0] SEED    = 32'h0000_0001,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              rclk,
  input  logic              arst_n,
  input  logic              start,
  input  logic [CWIDTH-1:0] rd_count,
  input  logic              pat_sel,
  input  logic              pause,
  input  logic              fifo_empty,
  input  logic              fifo_rdv,
  input  logic [DWIDTH-1:0] fifo_rdata,
  output logic              fifo_rrq,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              timeout,
  output logic [CWIDTH-1:0] rx_count,
  output logic [CWIDTH-1:0] err_count,
  output logic [CWIDTH-1:0] first_err_idx,
  output logic [DWIDTH-1:0] first_err_exp,
  output logic [DWIDTH-1:0] first_err_got
);

  localparam int unsigned TW        = $clog2(TIMEOUT + 1);
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CWIDTH-1:0]   rd_count_q, rd_count_d;
  logic                pat_sel_q, pat_sel_d;
  logic [CWIDTH-1:0]   issued_q, issued_d;
  logic [CWIDTH-1:0]   rx_count_q, rx_count_d;
  logic [CWIDTH-1:0]   err_count_q, err_count_d;
  logic                error_q, error_d;
  logic                timeout_q, timeout_d;
  logic [CWIDTH-1:0]   fe_idx_q, fe_idx_d;
  logic [DWIDTH-1:0]   fe_exp_q, fe_exp_d;
  logic [DWIDTH-1:0]   fe_got_q, fe_got_d;
  logic [31:0]         exp_q, exp_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic                rrq_q, rrq_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [CWIDTH:0]     issue_sum;
  logic [31:0]         exp_next;
  logic                mismatch;
  logic                tmo_hit;

  // A request already on the wire counts toward the issue budget even if it is not yet reflected in issued_q.
  assign issue_sum = {1'b0, issued_q} + {{CWIDTH{1'b0}}, rrq_q};
  assign exp_next  = pat_sel_q ? ((exp_q >> 1) ^ (exp_q[0] ? LFSR_TAPS : 32'h0)) : exp_q + 32'd1;
  assign mismatch  = (fifo_rdata != exp_q[DWIDTH-1:0]);
  assign tmo_hit   = !fifo_rdv && !pause && (tmo_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    rd_count_d  = rd_count_q;
    pat_sel_d   = pat_sel_q;
    issued_d    = issued_q;
    rx_count_d  = rx_count_q;
    err_count_d = err_count_q;
    error_d     = error_q;
    timeout_d   = timeout_q;
    fe_idx_d    = fe_idx_q;
    fe_exp_d    = fe_exp_q;
    fe_got_d    = fe_got_q;
    exp_d       = exp_q;
    tmo_d       = tmo_q;
    rrq_d       = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          rd_count_d  = rd_count;
          pat_sel_d   = pat_sel;
          issued_d    = '0;
          rx_count_d  = '0;
          err_count_d = '0;
          error_d     = 1'b0;
          timeout_d   = 1'b0;
          fe_idx_d    = '0;
          fe_exp_d    = '0;
          fe_got_d    = '0;
          exp_d       = SEED;
          tmo_d       = '0;
          state_d     = (rd_count == '0) ? S_DONE : S_READ;
        end else if (fifo_rdv) begin
          error_d = 1'b1;
        end
      end
      default: begin
        issued_d = issue_sum[CWIDTH-1:0];
        if (fifo_rdv) begin
          rx_count_d = rx_count_q + 1'b1;
          exp_d      = exp_next;
          tmo_d      = '0;
          if (mismatch) begin
            error_d = 1'b1;
            if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
            if (err_count_q == '0) begin
              fe_idx_d = rx_count_q;
              fe_exp_d = exp_q[DWIDTH-1:0];
              fe_got_d = fifo_rdata;
            end
          end
        end else if (!pause) begin
          tmo_d = tmo_q + 1'b1;
        end

        if (tmo_hit) begin
          timeout_d = 1'b1;
          error_d   = 1'b1;
          state_d   = S_DONE;
        end else if (state_q == S_READ && issued_q == rd_count_q) begin
          state_d = S_DRAIN;
        end else if (state_q == S_DRAIN && rx_count_q == rd_count_q) begin
          state_d = S_DONE;
        end

        rrq_d = (state_q == S_READ) && (state_d == S_READ) && !fifo_empty && !pause &&
                (issue_sum < {1'b0, rd_count_q});
      end
    endcase

    busy_d = (state_d == S_READ) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge rclk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= S_IDLE;
      rd_count_q  <= '0;
      pat_sel_q   <= 1'b0;
      issued_q    <= '0;
      rx_count_q  <= '0;
      err_count_q <= '0;
      error_q     <= 1'b0;
      timeout_q   <= 1'b0;
      fe_idx_q    <= '0;
      fe_exp_q    <= '0;
      fe_got_q    <= '0;
      exp_q       <= SEED;
      tmo_q       <= '0;
      rrq_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_count_q  <= rd_count_d;
      pat_sel_q   <= pat_sel_d;
      issued_q    <= issued_d;
      rx_count_q  <= rx_count_d;
      err_count_q <= err_count_d;
      error_q     <= error_d;
      timeout_q   <= timeout_d;
      fe_idx_q    <= fe_idx_d;
      fe_exp_q    <= fe_exp_d;
      fe_got_q    <= fe_got_d;
      exp_q       <= exp_d;
      tmo_q       <= tmo_d;
      rrq_q       <= rrq_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign fifo_rrq      = rrq_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign timeout       = timeout_q;
  assign rx_count      = rx_count_q;
  assign err_count     = err_count_q;
  assign first_err_idx = fe_idx_q;
  assign first_err_exp = fe_exp_q;
  assign first_err_got = fe_got_q;

endmodule

// File: doc/fifo_rd_checker.md
FIFO_RD_CHECKER -- requirements
Module: fifo_rd_checker

Interface
REQ-001 Parameter DWIDTH, default 8: FIFO data width.
REQ-002 Parameter CWIDTH, default 16: width of word counters and error counter.
REQ-003 Parameter SEED, default 32'h0000_0001: initial expected-pattern value, nonzero.
REQ-004 Parameter TIMEOUT, default 1024: idle read-side cycles before timeout.
REQ-005 rclk  in  1  read-domain clock; only clock in the block.
REQ-006 arst_n  in  1  asynchronous active-low reset.
REQ-007 start  in  1  one-cycle pulse that launches a check run.
REQ-008 rd_count  in  CWIDTH  words to read in the run; sampled on start.
REQ-009 pat_sel  in  1  0 = incrementing pattern, 1 = LFSR pattern; sampled on start.
REQ-010 pause  in  1  throttle; suppresses new requests while high.
REQ-011 fifo_empty  in  1  FIFO empty flag, rclk domain.
REQ-012 fifo_rdv  in  1  fifo_rdata valid this cycle.
REQ-013 fifo_rdata  in  DWIDTH  FIFO read data.
REQ-014 fifo_rrq  out  1  read request to FIFO.
REQ-015 busy / done  out  1 each  run active / run finished (level).
REQ-016 error  out  1  sticky: any mismatch, spurious rdv or timeout this run.
REQ-017 timeout  out  1  sticky: run aborted by timeout.
REQ-018 rx_count, err_count  out  CWIDTH each  words received / mismatches.
REQ-019 first_err_idx out CWIDTH; first_err_exp, first_err_got out DWIDTH each  capture of first mismatch.

Function
REQ-020 FIFO contract: fifo_rrq sampled at posedge rclk with fifo_empty low pops one word; fifo_rdv and fifo_rdata valid exactly one cycle later.
REQ-021 States IDLE, READ, DRAIN, DONE; all registers update on posedge rclk.
REQ-022 IDLE/DONE + start: load rd_count, pat_sel; clear rx_count, err_count, error, timeout, first_err_*, issue counter; expected = SEED; go READ, or DONE directly when rd_count == 0.
REQ-023 fifo_rrq registered: high in next cycle iff state READ, !fifo_empty, !pause, and issued + (request this cycle) < rd_count; at most rd_count requests per run.
REQ-024 READ -> DRAIN when issued == rd_count; DRAIN -> DONE when rx_count == rd_count.
REQ-025 On fifo_rdv in READ/DRAIN: compare fifo_rdata to expected[DWIDTH-1:0]; increment rx_count; advance expected.
REQ-026 Increment pattern: expected + 1 mod 2^32. LFSR pattern: 32-bit Galois, taps 0x8020_0003, shift right, XOR taps when LSB was 1.
REQ-027 Mismatch: err_count += 1, saturating at 2^CWIDTH-1; error set; first mismatch only latches first_err_idx = rx_count (pre-increment), exp, got.
REQ-028 fifo_rdv in IDLE or DONE: spurious; error set; no counter change.
REQ-029 Timeout counter clears on each fifo_rdv and on start; counts in READ/DRAIN while pause low; at TIMEOUT: timeout and error set, fifo_rrq low, go DONE.
REQ-030 start while READ/DRAIN ignored.
REQ-031 busy = state in {READ, DRAIN}; done = state DONE; done holds until next start.
REQ-032 fifo_empty rising while request issued: request already registered is counted; FIFO contract governs rdv.

Reset
REQ-033 arst_n low: immediately state IDLE, fifo_rrq 0, busy 0, done 0, error 0, timeout 0, all counters and captures 0, expected = SEED.
REQ-034 arst_n deassertion takes effect at next posedge rclk; reset mid-run abandons the run, no done pulse.

Verification
REQ-035 rd_count=20, pat_sel=0, SEED=1, model FIFO preloaded 0x01..0x14 -> done, rx_count 20, err_count 0, error 0, exactly 20 rrq cycles.
REQ-036 Same as 035 with word 7 corrupted to 0xFF -> err_count 1, first_err_idx 6, first_err_exp 0x07, first_err_got 0xFF, error 1.
REQ-037 pat_sel=1, rd_count=300, FIFO fed LFSR stream, empty toggled every 5 cycles, pause random -> no rrq while empty or paused, rx_count 300, error 0; increment run of 300 checks 8-bit wrap 0xFF -> 0x00.
REQ-038 rd_count=10, FIFO delivers 4 words then stays empty, TIMEOUT=16 -> timeout 1, error 1, rx_count 4, done 1, 16 cycles after last rdv.
REQ-039 rdv pulse in IDLE -> error 1, rx_count 0; rd_count=0 start -> done next cycle, no rrq.
REQ-040 arst_n low mid-DRAIN -> all outputs reset values asynchronously; new start after release completes normally.
